// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
// Holds func3 encodings, the M-extension func7 value and FSM states.
package ex_muldiv_pkg;

   localparam logic [2:0] INST_MUL    = 3'd0;
   localparam logic [2:0] INST_MULH   = 3'd1;
   localparam logic [2:0] INST_MULHSU = 3'd2;
   localparam logic [2:0] INST_MULHU  = 3'd3;
   localparam logic [2:0] INST_DIV    = 3'd4;
   localparam logic [2:0] INST_DIVU   = 3'd5;
   localparam logic [2:0] INST_REM    = 3'd6;
   localparam logic [2:0] INST_REMU   = 3'd7;

   localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   function automatic logic op_sgn1(input logic [2:0] op);
      return op inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM};
   endfunction

   function automatic logic op_sgn2(input logic [2:0] op);
      return op inside {INST_MULH, INST_DIV, INST_REM};
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/writeback bundle between EX and the multi-cycle M unit.
// master = EX side, slave = ex_muldiv.
interface ex_muldiv_if #(
   parameter int XLEN = 32
);
   import ex_muldiv_pkg::*;

   logic            start_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic [4:0]      rd_addr_i;
   logic            flush_i;
   logic            busy_o;
   logic            hold_flag_o;
   logic [XLEN-1:0] rd_data_o;
   logic [4:0]      rd_addr_o;
   logic            rd_wen_o;

   modport master (
      output start_i, op_i, op1_i, op2_i,
      output rd_addr_i, flush_i,
      input  busy_o, hold_flag_o,
      input  rd_data_o, rd_addr_o, rd_wen_o
   );

   modport slave (
      input  start_i, op_i, op1_i, op2_i,
      input  rd_addr_i, flush_i,
      output busy_o, hold_flag_o,
      output rd_data_o, rd_addr_o, rd_wen_o
   );

endinterface

// File: rtl/md_div_core.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
// o_last is high during the final iteration; results hold afterwards.
module md_div_core
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_quot,
   output logic [XLEN-1:0] o_rem,
   output logic            o_last
);

   localparam int CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quot;
   logic [XLEN-1:0] r_dvsr;
   logic [CW-1:0]   r_cnt;
   logic            r_run;

   logic [XLEN:0]   w_sh;
   logic [XLEN:0]   w_diff;
   logic            w_ge;

   // Partial remainder stays below the divisor, so XLEN+1 bits suffice.
   assign w_sh   = {r_rem, r_quot[XLEN-1]};
   assign w_diff = w_sh - {1'b0, r_dvsr};
   assign w_ge   = ~w_diff[XLEN];
   assign o_last = r_run & (r_cnt == CW'(1));
   assign o_quot = r_quot;
   assign o_rem  = r_rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_quot <= '0;
         r_dvsr <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
      end else if (i_flush) begin
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_start) begin
         r_rem  <= '0;
         r_quot <= i_dividend;
         r_dvsr <= i_divisor;
         r_cnt  <= CW'(XLEN);
         r_run  <= 1'b1;
      end else if (r_run) begin
         r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
         r_quot <= {r_quot[XLEN-2:0], w_ge};
         r_cnt  <= r_cnt - CW'(1);
         if (o_last) r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit beside the EX ALU.
// Shift-add multiplier and sign handling here; divide in md_div_core.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1,
   parameter int DIV_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   ex_muldiv_if.slave io_md
);

   localparam int CW      = $clog2(XLEN + 1);
   localparam int PW      = XLEN + MUL_BITS;
   localparam int MUL_CNT = XLEN / MUL_BITS;
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   if (DIV_BITS != 1 || (XLEN % MUL_BITS) != 0 || MUL_BITS >= XLEN)
   begin : g_param_chk
      $error("ex_muldiv: unsupported parameter set");
   end

   md_state_e         r_state;
   md_state_e         w_next;
   md_state_e         w_acc_state;

   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_mcand;
   logic [2*XLEN-1:0] r_prod;
   logic [CW-1:0]     r_cnt;
   logic              r_neg;
   logic              r_sign1;
   logic              r_special;
   logic [XLEN-1:0]   r_spec;

   logic              w_accept;
   logic              w_busy;
   logic              w_wen;
   logic              w_neg1;
   logic              w_neg2;
   logic [XLEN-1:0]   w_mag1;
   logic [XLEN-1:0]   w_mag2;
   logic              w_is_div;
   logic              w_div0;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_spec;
   logic              w_div_start;
   logic              w_div_last;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;
   logic [PW-1:0]     w_pp;
   logic [PW-1:0]     w_hi;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_result;

   assign w_busy   = (r_state == MD_MUL) | (r_state == MD_DIV);
   assign w_accept = io_md.start_i & ~io_md.flush_i &
                     ((r_state == MD_IDLE) | (r_state == MD_DONE));

   assign w_neg1 = op_sgn1(io_md.op_i) & io_md.op1_i[XLEN-1];
   assign w_neg2 = op_sgn2(io_md.op_i) & io_md.op2_i[XLEN-1];
   assign w_mag1 = w_neg1 ? -io_md.op1_i : io_md.op1_i;
   assign w_mag2 = w_neg2 ? -io_md.op2_i : io_md.op2_i;

   assign w_is_div  = io_md.op_i[2];
   assign w_div0    = (io_md.op2_i == '0);
   assign w_ovf     = op_sgn1(io_md.op_i) & w_is_div &
                      (io_md.op1_i == SMIN) & (io_md.op2_i == '1);
   assign w_special = w_is_div & (w_div0 | w_ovf);

   // op_i[1] separates REM/REMU from DIV/DIVU.
   always_comb begin
      w_spec = '0;
      if (w_div0)
         w_spec = io_md.op_i[1] ? io_md.op1_i : '1;
      else
         w_spec = io_md.op_i[1] ? '0 : io_md.op1_i;
   end

   assign w_div_start = w_accept & w_is_div & ~w_special;
   assign w_acc_state = !w_is_div ? MD_MUL :
                        (w_special ? MD_DONE : MD_DIV);

   md_div_core #(
      .XLEN (XLEN)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst),
      .i_start    (w_div_start),
      .i_flush    (io_md.flush_i),
      .i_dividend (w_mag1),
      .i_divisor  (w_mag2),
      .o_quot     (w_quot),
      .o_rem      (w_rem),
      .o_last     (w_div_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= MD_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (io_md.flush_i) begin
         w_next = MD_IDLE;
      end else begin
         unique case (r_state)
            MD_IDLE: if (w_accept) w_next = w_acc_state;
            MD_MUL:  if (r_cnt == CW'(1)) w_next = MD_DONE;
            MD_DIV:  if (w_div_last) w_next = MD_DONE;
            MD_DONE: w_next = w_accept ? w_acc_state : MD_IDLE;
            default: w_next = MD_IDLE;
         endcase
      end
   end

   assign w_pp = PW'(r_mcand) * PW'(r_prod[MUL_BITS-1:0]);
   assign w_hi = PW'(r_prod[2*XLEN-1:XLEN]) + w_pp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op      <= '0;
         r_rd      <= '0;
         r_mcand   <= '0;
         r_prod    <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_sign1   <= 1'b0;
         r_special <= 1'b0;
         r_spec    <= '0;
      end else if (w_accept) begin
         r_op      <= io_md.op_i;
         r_rd      <= io_md.rd_addr_i;
         r_mcand   <= w_mag1;
         r_prod    <= {{XLEN{1'b0}}, w_mag2};
         r_cnt     <= CW'(MUL_CNT);
         r_neg     <= w_neg1 ^ w_neg2;
         r_sign1   <= w_neg1;
         r_special <= w_special;
         r_spec    <= w_spec;
      end else if (r_state == MD_MUL) begin
         r_prod <= {w_hi, r_prod[XLEN-1:MUL_BITS]};
         r_cnt  <= r_cnt - CW'(1);
      end
   end

   assign w_prod_s = r_neg ? -r_prod : r_prod;

   always_comb begin
      w_result = '0;
      if (r_special)
         w_result = r_spec;
      else if (!r_op[2])
         w_result = (r_op == INST_MUL) ? w_prod_s[XLEN-1:0]
                                       : w_prod_s[2*XLEN-1:XLEN];
      else if (!r_op[1])
         w_result = r_neg ? -w_quot : w_quot;
      else
         w_result = r_sign1 ? -w_rem : w_rem;
   end

   // Flush beats writeback so a killed op never reaches the regfile.
   assign w_wen             = (r_state == MD_DONE) & ~io_md.flush_i;
   assign io_md.rd_wen_o    = w_wen;
   assign io_md.rd_data_o   = w_wen ? w_result : '0;
   assign io_md.rd_addr_o   = w_wen ? r_rd : '0;
   assign io_md.busy_o      = w_busy;
   assign io_md.hold_flag_o = w_busy | w_accept;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv with MUL_BITS=1 and MUL_BITS=4 instances.
// Stimulus pushes expected writebacks; a negedge monitor pops and checks.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q4[$];

   ex_muldiv_if #(.XLEN(32)) bus0 ();
   ex_muldiv_if #(.XLEN(32)) bus4 ();

   ex_muldiv #(.XLEN(32), .MUL_BITS(1), .DIV_BITS(1)) u_dut0 (
      .clk   (clk),
      .rst   (rst),
      .io_md (bus0)
   );

   ex_muldiv #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(1)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .io_md (bus4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic mon_step(input int w, input logic wen,
                           input logic [31:0] d, input logic [4:0] a);
      exp_t e;
      bit   have;
      have = (w == 0) ? (q0.size() > 0) : (q4.size() > 0);
      if (have) e = (w == 0) ? q0[0] : q4[0];
      if (wen) begin
         if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wen dut%0d: got data=%h rd=%0d, expected no writeback",
                     w, d, a);
         end else begin
            if (w == 0) void'(q0.pop_front());
            else        void'(q4.pop_front());
            chk($sformatf("data dut%0d rd%0d", w, e.rd), d, e.data);
            chk($sformatf("rd_addr dut%0d", w), {27'd0, a}, {27'd0, e.rd});
            chk($sformatf("latency dut%0d rd%0d", w, e.rd), cyc, e.due);
         end
      end else begin
         chk($sformatf("idle_zero dut%0d", w), {d[31:5], d[4:0] | a}, 32'd0);
         if (have && cyc > e.due) begin
            checks++;
            errors++;
            $display("FAIL missing_wen dut%0d rd%0d: got none by cycle %0d, expected at %0d",
                     w, e.rd, cyc, e.due);
            if (w == 0) void'(q0.pop_front());
            else        void'(q4.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      mon_step(0, bus0.rd_wen_o, bus0.rd_data_o, bus0.rd_addr_o);
      mon_step(1, bus4.rd_wen_o, bus4.rd_data_o, bus4.rd_addr_o);
   end

   task automatic drive(input int w, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic fl);
      if (w == 0) begin
         bus0.start_i = st; bus0.op_i = op; bus0.op1_i = a;
         bus0.op2_i = b; bus0.rd_addr_i = rd; bus0.flush_i = fl;
      end else begin
         bus4.start_i = st; bus4.op_i = op; bus4.op1_i = a;
         bus4.op2_i = b; bus4.rd_addr_i = rd; bus4.flush_i = fl;
      end
   endtask

   // Start is high for one cycle; returns #1 into the following cycle.
   task automatic issue(input int w, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int lat, input bit push);
      @(posedge clk) #1;
      drive(w, 1'b1, op, a, b, rd, 1'b0);
      if (push) begin
         if (w == 0) q0.push_back('{exp, rd, cyc + lat});
         else        q4.push_back('{exp, rd, cyc + lat});
      end
      @(negedge clk);
      if (push)
         chk($sformatf("hold_on_issue dut%0d rd%0d", w, rd),
             {31'd0, (w == 0) ? bus0.hold_flag_o : bus4.hold_flag_o}, 32'd1);
      @(posedge clk) #1;
      drive(w, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (q0.size() == 0 && q4.size() == 0) break;
         @(posedge clk);
      end
      if (q0.size() != 0 || q4.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending, expected 0",
                  q0.size(), q4.size());
         q0.delete();
         q4.delete();
      end
      @(posedge clk);
   endtask

   initial begin
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bus0.busy_o}, 32'd0);
      chk("rst_hold", {31'd0, bus0.hold_flag_o}, 32'd0);
      chk("rst_wen", {31'd0, bus0.rd_wen_o}, 32'd0);
      chk("rst_data", bus0.rd_data_o, 32'd0);
      chk("rst_wen4", {31'd0, bus4.rd_wen_o}, 32'd0);
      rst = 1'b1;

      // MUL 7 * -3 with hold profile
      issue(0, INST_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33, 1);
      repeat (31) @(posedge clk);
      @(negedge clk);
      chk("hold_c32", {31'd0, bus0.hold_flag_o}, 32'd1);
      chk("busy_c32", {31'd0, bus0.busy_o}, 32'd1);
      @(negedge clk);
      chk("hold_c33", {31'd0, bus0.hold_flag_o}, 32'd0);
      wait_drain(10);

      issue(0, INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33, 1);
      wait_drain(50);
      issue(0, INST_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 33, 1);
      wait_drain(50);
      issue(0, INST_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 33, 1);
      wait_drain(50);

      issue(1, INST_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 9, 1);
      wait_drain(20);
      issue(1, INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 32'hFFFF_FFFE, 9, 1);
      wait_drain(20);

      issue(0, INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 1);
      wait_drain(50);
      issue(0, INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 1);
      wait_drain(50);
      issue(0, INST_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1);
      wait_drain(50);
      issue(0, INST_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33, 1);
      wait_drain(50);

      issue(0, INST_DIV, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 1);
      wait_drain(10);
      issue(0, INST_REMU, 32'h1234, 32'd0, 5'd10, 32'h1234, 1, 1);
      wait_drain(10);
      issue(0, INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 1);
      wait_drain(10);
      issue(0, INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1, 1);
      wait_drain(10);

      // flush at cycle 10 of a DIV
      issue(0, INST_DIV, 32'd1000, 32'd3, 5'd13, 32'd0, 0, 0);
      repeat (9) @(posedge clk);
      #1 bus0.flush_i = 1'b1;
      @(posedge clk) #1 bus0.flush_i = 1'b0;
      chk("flush_busy", {31'd0, bus0.busy_o}, 32'd0);
      chk("flush_hold", {31'd0, bus0.hold_flag_o}, 32'd0);
      repeat (40) @(posedge clk);

      // flush coincident with start
      @(posedge clk) #1;
      drive(0, 1'b1, INST_DIV, 32'd9, 32'd3, 5'd14, 1'b1);
      @(negedge clk);
      chk("coinc_hold", {31'd0, bus0.hold_flag_o}, 32'd0);
      @(posedge clk) #1;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("coinc_busy", {31'd0, bus0.busy_o}, 32'd0);
      repeat (40) @(posedge clk);

      // flush during DONE suppresses writeback
      issue(0, INST_DIV, 32'd5, 32'd0, 5'd15, 32'd0, 0, 0);
      bus0.flush_i = 1'b1;
      @(negedge clk);
      chk("flush_done_wen", {31'd0, bus0.rd_wen_o}, 32'd0);
      @(posedge clk) #1 bus0.flush_i = 1'b0;
      repeat (5) @(posedge clk);

      // start while busy is ignored
      issue(0, INST_DIVU, 32'd100, 32'd7, 5'd16, 32'd14, 33, 1);
      repeat (3) @(posedge clk);
      #1 drive(0, 1'b1, INST_MUL, 32'd2, 32'd3, 5'd17, 1'b0);
      @(posedge clk) #1 drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      wait_drain(50);

      // back-to-back: second start lands in the DONE cycle
      issue(0, INST_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 33, 1);
      repeat (31) @(posedge clk);
      issue(0, INST_REMU, 32'd100, 32'd7, 5'd21, 32'd2, 33, 1);
      wait_drain(50);

      // reset at cycle 5 of a MUL
      issue(0, INST_MUL, 32'd7, 32'd9, 5'd22, 32'd0, 0, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rstmid_busy", {31'd0, bus0.busy_o}, 32'd0);
      chk("rstmid_hold", {31'd0, bus0.hold_flag_o}, 32'd0);
      chk("rstmid_wen", {31'd0, bus0.rd_wen_o}, 32'd0);
      @(posedge clk) #1 rst = 1'b1;
      repeat (40) @(posedge clk);

      wait_drain(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule
